// File: rtl/mux_nway_rr_if.sv
// Channel-select bus: WAYS valid/ready input channels, select controls and one
// valid/ready output channel.
interface mux_nway_rr_if #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = 3
);
  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_chan;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/mux_nway_rr.sv
// WAYS-to-1 registered channel select, fixed-select or round-robin arbitration,
// valid/ready on every channel with a single output register stage.
module mux_nway_rr #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = 3
) (
  input logic          clk,
  input logic          reset,
  mux_nway_rr_if.slave bus
);

  logic [WAYS-1:0][WIDTH-1:0] chan;
  logic [SEL_W-1:0]           ptr, gidx, idx;
  logic                       gvld, load;
  logic [WAYS-1:0]            rdy;
  logic [WIDTH-1:0]           data_q;
  logic [SEL_W-1:0]           chan_q;
  logic                       vld_q;

  assign chan = bus.in_data;
  assign load = !vld_q || bus.out_ready;

  // RR search starts one past the last granted channel and wraps mod WAYS.
  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    idx  = '0;
    if (bus.mode) begin
      for (int i = 0; i < WAYS; i++) begin
        idx = SEL_W'((int'(ptr) + 1 + i) % WAYS);
        if (!gvld && bus.in_valid[idx]) begin
          gvld = 1'b1;
          gidx = idx;
        end
      end
    end else if (int'(bus.sel) < WAYS) begin
      gvld = bus.in_valid[bus.sel];
      gidx = bus.sel;
    end
  end

  always_comb begin
    rdy = '0;
    if (!reset && load && gvld) rdy[gidx] = 1'b1;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = vld_q;

  // A grant under load is exactly the in_valid && in_ready transfer condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      ptr    <= SEL_W'(WAYS - 1);
    end else if (load) begin
      if (gvld) begin
        vld_q  <= 1'b1;
        data_q <= chan[gidx];
        chan_q <= gidx;
        if (bus.mode) ptr <= gidx;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nway_rr.sv
// Directed bench for mux_nway_rr: expected words queued when a grant is expected,
// popped and compared once the output register updates.
module tb_mux_nway_rr;
  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SEL_W = 3;

  logic clk, reset;
  logic [WAYS-1:0][WIDTH-1:0] words;
  logic [WIDTH+SEL_W-1:0] sb[$];
  logic [WIDTH+SEL_W-1:0] held;
  int checks, failures;

  mux_nway_rr_if #(.WIDTH(WIDTH), .WAYS(WAYS), .SEL_W(SEL_W)) bus ();

  mux_nway_rr #(.WIDTH(WIDTH), .WAYS(WAYS), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.in_data = words;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven (at negedge); check in_ready, then the output after the edge.
  task automatic step(input logic [WAYS-1:0] er, input logic ev, input string tag);
    logic [WIDTH+SEL_W-1:0] e;
    int g;
    #1;
    chk(32'(bus.in_ready), 32'(er), {tag, ":in_ready"});
    if (er != '0) begin
      g = 0;
      for (int k = 0; k < WAYS; k++) if (er[k]) g = k;
      sb.push_back({words[g], SEL_W'(g)});
    end
    @(posedge clk);
    #1;
    chk(32'(bus.out_valid), 32'(ev), {tag, ":out_valid"});
    if (er != '0) begin
      if (sb.size() == 0) begin
        chk(32'(1), 32'(0), {tag, ":scoreboard_empty"});
      end else begin
        e = sb.pop_front();
        held = e;
      end
    end
    chk(32'(bus.out_data), 32'(held[WIDTH+SEL_W-1:SEL_W]), {tag, ":out_data"});
    chk(32'(bus.out_chan), 32'(held[SEL_W-1:0]), {tag, ":out_chan"});
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; held = '0;
    words = '0;
    reset = 1'b1;
    bus.in_valid = '1; bus.mode = 1'b1; bus.sel = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk(32'(bus.in_ready), 32'(0), "rst:in_ready");
    chk(32'(bus.out_valid), 32'(0), "rst:out_valid");
    chk(32'(bus.out_data), 32'(0), "rst:out_data");
    chk(32'(bus.out_chan), 32'(0), "rst:out_chan");
    bus.in_valid = '0;
    reset = 1'b0;
    @(negedge clk);

    // Fixed select of channel 2
    bus.mode = 1'b0; bus.sel = 3'd2; words[2] = 16'h0010; bus.in_valid = 8'b0000_0100;
    step(8'b0000_0100, 1'b1, "fix_c");
    // Fixed select of an invalid channel: word drains, output goes empty, data holds
    bus.sel = 3'd5; bus.in_valid = 8'b1101_1111;
    step(8'h00, 1'b0, "fix_f_invalid");

    // Round-robin across all channels; pointer untouched by fixed mode so starts at 0
    bus.mode = 1'b1; bus.in_valid = '1;
    for (int k = 0; k < WAYS; k++) words[k] = WIDTH'(k + 1);
    for (int k = 0; k < 10; k++) step(WAYS'(1 << (k % WAYS)), 1'b1, "rr_all");

    // Async reset between edges
    #2 reset = 1'b1;
    #1;
    chk(32'(bus.out_valid), 32'(0), "arst:out_valid");
    chk(32'(bus.out_data), 32'(0), "arst:out_data");
    chk(32'(bus.out_chan), 32'(0), "arst:out_chan");
    chk(32'(bus.in_ready), 32'(0), "arst:in_ready");
    bus.in_valid = '0;
    #1 reset = 1'b0;
    held = '0;
    @(posedge clk);
    #1;
    chk(32'(bus.out_valid), 32'(0), "arst:no_rerequest");
    @(negedge clk);

    // Two valid channels alternate, first grant is the lowest after reset
    words[1] = 16'h0730; words[6] = 16'hc080; bus.in_valid = 8'b0100_0010;
    step(8'b0000_0010, 1'b1, "rr_bg0");
    step(8'b0100_0000, 1'b1, "rr_bg1");
    step(8'b0000_0010, 1'b1, "rr_bg2");
    step(8'b0100_0000, 1'b1, "rr_bg3");

    // Stall holds the word, then drain and fill on the same edge
    bus.mode = 1'b0; bus.sel = 3'd0; words[0] = 16'ha211; bus.in_valid = 8'b0000_0001;
    step(8'b0000_0001, 1'b1, "stall_load");
    bus.out_ready = 1'b0; bus.in_valid = '1; words[0] = 16'h1111;
    for (int k = 0; k < 3; k++) step(8'h00, 1'b1, "stall_hold");
    bus.out_ready = 1'b1;
    step(8'b0000_0001, 1'b1, "stall_drain_fill");

    // Fixed->RR keeps the pointer (last RR grant was 6), then wraps to 0
    bus.mode = 1'b1; bus.in_valid = '1;
    step(8'b1000_0000, 1'b1, "rr_keep_ptr");
    step(8'b0000_0001, 1'b1, "rr_wrap");

    // Single continuously valid channel is granted every cycle
    words[3] = 16'h3c3c; bus.in_valid = 8'b0000_1000;
    for (int k = 0; k < 3; k++) step(8'b0000_1000, 1'b1, "rr_single");
    bus.in_valid = '0;
    step(8'h00, 1'b0, "rr_none");

    chk(32'(sb.size()), 32'(0), "scoreboard_drained");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_nway_rr.md
Name: mux_nway_rr

Overview:
- Parametrised, registered successor to the 16-bit 8-way multiplexer: it selects one of WAYS input channels, each WIDTH bits wide.
- Selection is either by an explicit select input (fixed mode) or by a round-robin arbiter over per-channel valid flags (RR mode).
- Every channel input and the single output use valid/ready handshakes, with one output register stage.
- Used as the channel-select stage ahead of memory/ALU consumers that may stall.

Parameters:
- WIDTH, 16, bits per channel word.
- WAYS, 8, number of input channels; legal range 2..16.
- SEL_W, 3, select/channel-index width; must be at least ceil(log2(WAYS)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WAYS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  WAYS  per-channel word-available flag.
- in_ready  out  WAYS  per-channel accept strobe; at most one bit high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode; ignored in RR mode.
- out_data  out  WIDTH  registered selected word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_chan  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async, while high):
  - out_valid=0, out_data=0, out_chan=0.
  - Internal RR pointer ptr=WAYS-1, so the first RR search starts at channel 0.
  - in_ready is all zero whenever reset is high.
- load = !out_valid || out_ready (the output register is empty or is being drained this cycle).
- Grant, combinational, evaluated each cycle:
  - Fixed mode: grant channel sel if sel<WAYS and in_valid[sel]=1; otherwise no grant. Out-of-range sel always gives no grant.
  - RR mode: grant the first channel with in_valid=1, searching (ptr+1), (ptr+2), ... mod WAYS. No valid channel gives no grant.
- in_ready[g] = load && grant exists && g is the granted channel; all other bits are 0.
  - in_ready depends combinationally on in_valid, mode, sel and out_ready. This path is intended.
- Transfer occurs on a clock edge where in_valid[g] && in_ready[g]. Then:
  - out_data <= channel g word;
  - out_chan <= g;
  - out_valid <= 1;
  - ptr <= g, only when mode=1.
- If load=1 and there is no grant: out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold stable; in_ready is all zero; ptr holds.
- Latency: a word appears on out_data one cycle after its transfer edge.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and fill: the new word replaces the old one on the same edge, with no bubble.
- Mode or sel change:
  - Affects only the grant for the next transfer; a held output word is never altered.
  - Switching fixed->RR keeps the current ptr; ptr is not updated while in fixed mode.
- RR wrap-around: after granting WAYS-1, the search resumes at 0.
  - A single continuously valid channel is granted every cycle.
- Reset asserted mid-operation: outputs clear immediately (asynchronously); the in-flight word is dropped and not re-requested.
- A channel word is sampled only on its transfer edge; in_data for non-granted channels is don't-care.

Test Plan:
- Reset, then fixed mode with sel=3'b010, c=16'h0010 valid, out_ready=1 -> in_ready=8'b00000100; out_data=16'h0010 and out_chan=2 on the next cycle.
- Fixed mode with sel=3'b101 and f not valid (all others valid) -> in_ready=0, out_valid drops to 0 after the current word drains.
- RR mode, all 8 valid (a=16'h0001..h=16'h0008), out_ready=1 for 10 cycles:
  - out_chan sequence is 0,1,2,3,4,5,6,7,0,1;
  - out_data tracks the channel values;
  - out_valid stays continuously 1.
- RR mode, only b (16'h0730) and g (16'hc080) valid, starting after reset -> grants alternate 1,6,1,6.
- Stall: out_valid=1 with word 16'ha211, out_ready=0 for 3 cycles -> out_data stays 16'ha211 and in_ready=0 throughout. Then out_ready=1 -> next word accepted on that same edge.
- Async reset pulsed mid-stream, between clock edges -> out_valid=0 and out_data=0 immediately. After release the first RR grant goes to the lowest valid channel.
